// File: rtl/mmu_job_arbiter.sv
// Round-robin arbiter that gives two job requesters turns on one 2x2 systolic array.
// For each granted job it clears the array, runs the feeder under a watchdog and returns a response.
module mmu_job_arbiter #(
  parameter int CYC_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [2*CYC_W-1:0] req_cycles,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic               rsp_error,
  output logic               mmu_clear,
  output logic               mmu_en,
  output logic [CYC_W-1:0]   mmu_cycle,
  input  logic               mmu_done,
  output logic               busy,
  output logic               owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             err_q, err_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [7:0]       wdog_q, wdog_d;

  logic             grant;
  logic [CYC_W-1:0] grant_cyc;

  // A single valid requester wins outright; a tie goes to whoever was not served last.
  assign grant     = (&req_valid) ? ~last_grant_q : req_valid[1];
  assign grant_cyc = grant ? req_cycles[CYC_W +: CYC_W] : req_cycles[0 +: CYC_W];

  // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    cyc_d        = cyc_q;
    wdog_d       = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d = grant;
          cyc_d   = grant_cyc;
          if (grant_cyc == '0) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        wdog_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        wdog_d = wdog_q + 8'd1;
        if (mmu_done) begin
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      cyc_q        <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      cyc_q        <= cyc_d;
      wdog_q       <= wdog_d;
    end
  end

  // req_ready is the only output that depends on inputs; it is forced low while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && (|req_valid) && !rst) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_error = (state_q == RESP) & err_q;
  assign mmu_clear = (state_q == CLEAR);
  assign mmu_en    = (state_q == RUN);
  assign mmu_cycle = mmu_en ? cyc_q : '0;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mmu_job_arbiter.sv
// Directed bench for mmu_job_arbiter: inputs change and outputs are sampled 1ns after each falling edge.
module tb_mmu_job_arbiter;

  localparam int CYC_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [5:0]       req_cycles;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic             rsp_error;
  logic             mmu_clear;
  logic             mmu_en;
  logic [2:0]       mmu_cycle;
  logic             mmu_done;
  logic             busy;
  logic             owner;

  int errors = 0;
  int checks = 0;

  mmu_job_arbiter #(.CYC_W(CYC_W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cycles(req_cycles), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_error(rsp_error),
    .mmu_clear(mmu_clear), .mmu_en(mmu_en), .mmu_cycle(mmu_cycle),
    .mmu_done(mmu_done), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b00; req_cycles = '0; rsp_ready = 2'b00; mmu_done = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_error, mmu_clear, mmu_en, mmu_cycle, busy, owner} !== 12'd0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {req_ready, rsp_valid, rsp_error, mmu_clear, mmu_en, mmu_cycle, busy, owner});
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    req_valid = 2'b01; req_cycles = 6'b000_101;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL basic_req_ready got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b00;
    checks++; if ({mmu_clear, mmu_en, busy, owner} !== 4'b1010) begin
      errors++; $display("FAIL basic_clear got=%b exp=1010", {mmu_clear, mmu_en, busy, owner});
    end
    tick();
    checks++; if ({mmu_clear, mmu_en, mmu_cycle} !== 5'b0_1_101) begin
      errors++; $display("FAIL basic_run got=%b exp=01101", {mmu_clear, mmu_en, mmu_cycle});
    end
    tick(); tick(); tick();
    mmu_done = 1'b1;
    tick(); mmu_done = 1'b0;
    checks++; if ({rsp_valid, rsp_error, mmu_en} !== 4'b0100) begin
      errors++; $display("FAIL basic_resp got=%b exp=0100", {rsp_valid, rsp_error, mmu_en});
    end
    tick();
    checks++; if ({rsp_valid, rsp_error} !== 3'b010) begin
      errors++; $display("FAIL basic_resp_hold got=%b exp=010", {rsp_valid, rsp_error});
    end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
    checks++; if ({busy, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL basic_idle got=%b exp=000", {busy, rsp_valid});
    end
  endtask

  task automatic test_zero_cycles();
    req_valid = 2'b10; req_cycles = 6'b000_111;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL zero_req_ready got=%b exp=10", req_ready); end
    tick(); req_valid = 2'b00;
    checks++; if ({rsp_valid, rsp_error, mmu_clear, mmu_en, owner, busy} !== 7'b10_1_0_0_1_1) begin
      errors++; $display("FAIL zero_resp got=%b exp=1010011", {rsp_valid, rsp_error, mmu_clear, mmu_en, owner, busy});
    end
    rsp_ready = 2'b10;
    tick(); rsp_ready = 2'b00;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_idle got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_oh;
    logic [2:0] exp_cyc;
    req_valid = 2'b11; req_cycles = {3'd2, 3'd1}; mmu_done = 1'b1; rsp_ready = 2'b11;
    for (int j = 0; j < 4; j++) begin
      exp_oh  = (j % 2 == 0) ? 2'b01 : 2'b10;
      exp_cyc = (j % 2 == 0) ? 3'd1 : 3'd2;
      #1;
      checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", j, req_ready, exp_oh); end
      tick(); tick();
      checks++; if ({mmu_en, mmu_cycle} !== {1'b1, exp_cyc}) begin
        errors++; $display("FAIL rr_run%0d got=%b exp=%b", j, {mmu_en, mmu_cycle}, {1'b1, exp_cyc});
      end
      tick();
      checks++; if ({rsp_valid, rsp_error} !== {exp_oh, 1'b0}) begin
        errors++; $display("FAIL rr_resp%0d got=%b exp=%b", j, {rsp_valid, rsp_error}, {exp_oh, 1'b0});
      end
      if (j == 3) begin req_valid = 2'b00; mmu_done = 1'b0; end
      tick();
    end
    rsp_ready = 2'b00;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle got=%b exp=0", busy); end
  endtask

  task automatic test_timeout(input int done_at);
    int n;
    logic exp_err;
    exp_err = (done_at == 0);
    req_valid = 2'b01; req_cycles = 6'b000_011;
    tick(); req_valid = 2'b00;
    tick();
    n = 0;
    while (mmu_en === 1'b1 && n < 40) begin
      n++;
      mmu_done = (n == done_at);
      tick();
    end
    mmu_done = 1'b0;
    checks++; if (n !== 15) begin errors++; $display("FAIL timeout_en_cycles(done_at=%0d) got=%0d exp=15", done_at, n); end
    checks++; if ({rsp_valid, rsp_error} !== {2'b01, exp_err}) begin
      errors++; $display("FAIL timeout_resp(done_at=%0d) got=%b exp=%b", done_at, {rsp_valid, rsp_error}, {2'b01, exp_err});
    end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
  endtask

  task automatic test_ignored_inputs();
    mmu_done = 1'b1;
    tick(); mmu_done = 1'b0;
    checks++; if ({busy, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL idle_done got=%b exp=000", {busy, rsp_valid});
    end
    req_valid = 2'b10; req_cycles = {3'd2, 3'd0};
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL nonowner_grant got=%b exp=10", req_ready); end
    tick(); req_valid = 2'b00;
    tick();
    checks++; if (mmu_cycle !== 3'd2) begin errors++; $display("FAIL nonowner_cycle got=%0d exp=2", mmu_cycle); end
    mmu_done = 1'b1;
    tick();
    rsp_ready = 2'b01;
    tick();
    checks++; if ({rsp_valid, rsp_error, busy} !== 4'b1001) begin
      errors++; $display("FAIL nonowner_ack got=%b exp=1001", {rsp_valid, rsp_error, busy});
    end
    rsp_ready = 2'b10; mmu_done = 1'b0;
    tick(); rsp_ready = 2'b00;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nonowner_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_job();
    req_valid = 2'b01; req_cycles = 6'b000_001;
    tick(); req_valid = 2'b00;
    tick(); mmu_done = 1'b1;
    tick(); mmu_done = 1'b0; rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
    req_valid = 2'b01; req_cycles = 6'b000_100;
    tick(); req_valid = 2'b00;
    tick();
    checks++; if (mmu_en !== 1'b1) begin errors++; $display("FAIL rstmid_run got=%b exp=1", mmu_en); end
    rst = 1'b1;
    #1;
    checks++; if ({mmu_en, busy, rsp_valid, mmu_clear} !== 5'b0) begin
      errors++; $display("FAIL rstmid_abort got=%b exp=00000", {mmu_en, busy, rsp_valid, mmu_clear});
    end
    tick(); rst = 1'b0;
    req_valid = 2'b11; req_cycles = {3'd3, 3'd4};
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_grant got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b00;
    tick();
    checks++; if ({owner, mmu_cycle} !== 4'b0_100) begin
      errors++; $display("FAIL rstmid_job got=%b exp=0100", {owner, mmu_cycle});
    end
    mmu_done = 1'b1;
    tick(); mmu_done = 1'b0;
    checks++; if ({rsp_valid, rsp_error} !== 3'b010) begin
      errors++; $display("FAIL rstmid_resp got=%b exp=010", {rsp_valid, rsp_error});
    end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_cycles();
    test_back_to_back();
    test_timeout(0);
    test_timeout(15);
    test_ignored_inputs();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit reached got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mmu_job_arbiter.md
Name: mmu_job_arbiter

Overview:
- Shares the single 2x2 systolic array and its feeder between two independent job requesters (e.g. host instruction path and a self-test/replay engine).
- Round-robin arbitration, one job in flight.
- Per job, the block sequences the array: clear the processing-element accumulators, then assert the feeder's enable with a cycle count, wait for done, and return a response to the owning requester.
- A watchdog aborts jobs whose feeder never signals done.

Parameters:
- CYC_W, 3, width of the compute-cycle count passed to the feeder.
- TIMEOUT, 15, maximum RUN cycles before a job is aborted with error (1..255).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  job request per requester, bit i = requester i; held until accepted.
- req_cycles  input  2*CYC_W  cycle count per requester; requester i in bits [i*CYC_W +: CYC_W].
- req_ready  output  2  accept strobe; a job transfers when req_valid[i] & req_ready[i].
- rsp_valid  output  2  job-complete response to owner; held until rsp_ready.
- rsp_ready  input  2  response acknowledge per requester.
- rsp_error  output  1  qualifies the asserted rsp_valid bit: 1 = timeout or illegal job.
- mmu_clear  output  1  one-cycle clear of the PE accumulators.
- mmu_en  output  1  feeder enable, high throughout RUN.
- mmu_cycle  output  CYC_W  latched cycle count to the feeder, valid while mmu_en.
- mmu_done  input  1  feeder completion pulse.
- busy  output  1  high in any state other than IDLE.
- owner  output  1  index of the current or last granted requester.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; last_grant = 1, so requester 0 wins the first tie; watchdog and latched count cleared.
- Reset mid-job aborts silently: no response is issued and mmu_en drops immediately.
- FSM states: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - req_ready is combinational (Mealy): in IDLE, req_ready[g] = 1 for exactly one g.
  - g is the requester with req_valid set. If both are set, g = ~last_grant.
  - On handshake: latch owner = g and cyc = req_cycles[g].
  - If cyc == 0: go to RESP with error = 1. The array is not touched.
  - Otherwise go to CLEAR.
  - With no req_valid, stay in IDLE with req_ready = 0.
- CLEAR: mmu_clear = 1 for exactly one cycle; mmu_en = 0; watchdog = 0; next state RUN.
- RUN:
  - mmu_en = 1 and mmu_cycle = cyc.
  - The watchdog increments each RUN cycle.
  - If mmu_done = 1: go to RESP with error = 0.
  - Else if watchdog == TIMEOUT-1: go to RESP with error = 1.
  - done and timeout in the same cycle: done wins, error = 0.
  - mmu_done outside RUN is ignored.
- RESP:
  - rsp_valid[owner] = 1 and rsp_error = error; both are held stable and mmu_en = 0.
  - On rsp_ready[owner]: set last_grant = owner and go to IDLE. rsp_ready on the non-owner bit is ignored.
- Latency: a handshake in cycle T gives mmu_clear in T+1 and the first mmu_en cycle in T+2. mmu_done in cycle D gives rsp_valid from D+1.
- Responses are registered outputs; req_ready is the only combinational output.
- req_valid and req_cycles changing while not granted have no effect.
- A requester may re-request in the same cycle it acks its response. Arbitration in the following IDLE cycle still favours the other requester if it is valid.
- busy = (state != IDLE).
- Back-to-back minimum job: 1 IDLE + 1 CLEAR + 1 RUN + 1 RESP = 4 cycles with immediate done and ack.

Test Plan:
- Reset, then req_valid=01 with cycles=5 → req_ready=01 in same cycle; mmu_clear=1 next cycle; mmu_en=1 with mmu_cycle=5 from T+2. Drive mmu_done after 4 RUN cycles → rsp_valid=01, rsp_error=0 next cycle, held until rsp_ready=01.
- Both requesters valid continuously, immediate done/ack → grants alternate 0,1,0,1. Four jobs complete with owner sequence 0,1,0,1.
- req_valid=10 with cycles=0 → grant, then RESP directly; rsp_valid=10, rsp_error=1; mmu_clear and mmu_en never asserted.
- Job with mmu_done never driven, TIMEOUT=15 → exactly 15 mmu_en cycles, then rsp_valid with rsp_error=1. Repeat with mmu_done on the 15th RUN cycle → rsp_error=0.
- Assert rst during RUN → same cycle mmu_en=0, busy=0, rsp_valid=00. After release with both valid → requester 0 granted.
- In RESP, pulse rsp_ready on the non-owner bit → no state change. mmu_done pulsed in IDLE/RESP → ignored.
